cache_mem_arbiter: RTL

Sequential arbiter between the instruction-cache fill path and the data-cache load/store path for the single main-memory port. It replaces the combinational I/D select with a registered grant. The grant is locked for the whole memory transaction and a bounded starvation guard protects the data side. It sits between `i_cache`/`d_cache` and the external memory interface in the pipelined IU + cache + TLB top level.

---
 rtl/cache_mem_arbiter_pkg.sv | 14 +
 rtl/cache_mem_arbiter_if.sv | 33 +++
 rtl/arb_starve_cnt.sv | 25 ++
 rtl/cache_mem_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared state encoding and defaults for the I/D memory arbiter
package cache_mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_I_BUSY = 2'd1;
    localparam arb_state_t ARB_D_BUSY = 2'd2;
    localparam arb_state_t ARB_DONE   = 2'd3;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CW_DEF         = 3;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache request/ready and memory port bundle seen by the arbiter
interface cache_mem_arbiter_if;

    logic        m_fetch;
    logic [31:0] m_i_a;
    logic        m_ld_st;
    logic        m_st;
    logic [31:0] m_d_a;
    logic [31:0] m_d_st_data;
    logic        mem_ready;
    logic [31:0] mem_a;
    logic [31:0] mem_st_data;
    logic        mem_access;
    logic        mem_write;
    logic        m_i_ready;
    logic        m_d_ready;
    logic        sel_i;
    logic        arb_busy;

    // master: the arbiter itself; slave: the caches plus the memory port
    modport master (
        input  m_fetch, m_i_a, m_ld_st, m_st, m_d_a, m_d_st_data, mem_ready,
        output mem_a, mem_st_data, mem_access, mem_write,
        output m_i_ready, m_d_ready, sel_i, arb_busy
    );

    modport slave (
        output m_fetch, m_i_a, m_ld_st, m_st, m_d_a, m_d_st_data, mem_ready,
        input  mem_a, mem_st_data, mem_access, mem_write,
        input  m_i_ready, m_d_ready, sel_i, arb_busy
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of I grants taken over a pending D request
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - registered I/D grant to the single memory port with D starvation guard
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CW         = CW_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    cache_mem_arbiter_if.master  bus
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        grant_i;
    logic        grant_d;
    logic        at_max;
    logic        busy;
    logic [31:0] a_q;
    logic [31:0] d_q;
    logic        wr_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // I wins a tie unless D has already been passed over STARVE_MAX times
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (bus.m_fetch && !(bus.m_ld_st && at_max)) begin
                    state_nxt = ARB_I_BUSY;
                    grant_i   = 1'b1;
                end else if (bus.m_ld_st) begin
                    state_nxt = ARB_D_BUSY;
                    grant_d   = 1'b1;
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (bus.mem_ready) begin
                    state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            a_q  <= '0;
            d_q  <= '0;
            wr_q <= 1'b0;
        end else if (grant_i) begin
            a_q  <= bus.m_i_a;
            wr_q <= 1'b0;
        end else if (grant_d) begin
            a_q  <= bus.m_d_a;
            d_q  <= bus.m_d_st_data;
            wr_q <= bus.m_st;
        end
    end

    always_comb begin
        busy            = (state == ARB_I_BUSY) || (state == ARB_D_BUSY);
        bus.mem_a       = a_q;
        bus.mem_st_data = d_q;
        bus.mem_access  = busy;
        bus.mem_write   = wr_q && busy;
        bus.sel_i       = (state == ARB_I_BUSY);
        bus.arb_busy    = busy;
        bus.m_i_ready   = bus.mem_ready && (state == ARB_I_BUSY);
        bus.m_d_ready   = bus.mem_ready && (state == ARB_D_BUSY);
    end

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_starve (
        .clk    (clk),
        .rst    (clr),
        .inc    (grant_i && bus.m_ld_st),
        .clr    (grant_d || (grant_i && !bus.m_ld_st)),
        .at_max (at_max)
    );

endmodule
